// File: rtl/fifo_gather_if.sv
// Handshake/data bundle for fifo_gather; err exists only when FIFO_GATHER_ERR_FLAG_EN is defined.
interface fifo_gather_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 4
);
  logic                             clear;
  logic                             wen;
  logic                             ren;
  logic [PAR_WRITE*DATA_WIDTH-1:0]  din;
  logic [PAR_READ*DATA_WIDTH-1:0]   dout;
  logic                             full;
  logic                             empty;
  logic                             ready;
  logic                             valid;
`ifdef FIFO_GATHER_ERR_FLAG_EN
  logic                             err;

  modport master (output clear, wen, ren, din,
                  input  dout, full, empty, ready, valid, err);
  modport slave  (input  clear, wen, ren, din,
                  output dout, full, empty, ready, valid, err);
`else
  modport master (output clear, wen, ren, din,
                  input  dout, full, empty, ready, valid);
  modport slave  (input  clear, wen, ren, din,
                  output dout, full, empty, ready, valid);
`endif
endinterface

// File: rtl/fifo_gather.sv
// Gathering width-converter FIFO: PAR_WRITE words in, PAR_READ words out per handshake.
// Optional sticky err output for ignored requests under FIFO_GATHER_ERR_FLAG_EN.
module fifo_gather #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 4
) (
  input  logic          clk,
  input  logic          rstn,
  fifo_gather_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DW    = DATA_WIDTH;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] free_words;
  logic          wacc;
  logic          racc;

  // Flags come from the registered count only, so same-cycle traffic never bypasses.
  assign free_words = CW'(DEPTH) - count;
  assign bus.ready  = (free_words >= CW'(PAR_WRITE));
  assign bus.valid  = (count >= CW'(PAR_READ));
  assign bus.full   = (count == CW'(DEPTH));
  assign bus.empty  = (count == '0);

  assign wacc = bus.wen && bus.ready && !bus.clear;
  assign racc = bus.ren && bus.valid && !bus.clear;

  always_comb begin
    count_nxt = count;
    if (wacc) count_nxt = count_nxt + CW'(PAR_WRITE);
    if (racc) count_nxt = count_nxt - CW'(PAR_READ);
  end

  // Read gather; pointer arithmetic truncates to AW bits so addresses wrap past the top.
  always_comb begin
    bus.dout = '0;
    for (int unsigned j = 0; j < PAR_READ; j++) begin
      bus.dout[j*DW +: DW] = mem[rptr + AW'(j)];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.clear) begin
      // Flush drops occupancy only; stored words are left in place.
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wacc) begin
        for (int unsigned k = 0; k < PAR_WRITE; k++) begin
          mem[wptr + AW'(k)] <= bus.din[k*DW +: DW];
        end
        wptr <= wptr + AW'(PAR_WRITE);
      end
      if (racc) begin
        rptr <= rptr + AW'(PAR_READ);
      end
      count <= count_nxt;
    end
  end

`ifdef FIFO_GATHER_ERR_FLAG_EN
  logic err_q;

  assign bus.err = err_q;

  // Sticky record of any request made while its flag was low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (bus.clear) begin
      err_q <= 1'b0;
    end else if ((bus.wen && !bus.ready) || (bus.ren && !bus.valid)) begin
      err_q <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_gather.sv
// Scoreboard bench for fifo_gather (default 8-deep, 1-in/4-out); driver queues expected reads, monitor checks them.
module tb_fifo_gather;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] sb [$];

  fifo_gather_if #(.DATA_WIDTH(8), .PAR_WRITE(1), .PAR_READ(4)) bus ();

  fifo_gather #(
    .ADDR_WIDTH(3), .DATA_WIDTH(8), .PAR_WRITE(1), .PAR_READ(4)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e_empty, input logic e_full,
                           input logic e_ready, input logic e_valid);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(e_empty));
    chk({tag, ".full"},  32'(bus.full),  32'(e_full));
    chk({tag, ".ready"}, 32'(bus.ready), 32'(e_ready));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(e_valid));
  endtask

  // One clock of stimulus; returns #1 after the edge with requests dropped.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c,
                      input logic exp_rd, input logic [31:0] exp_val);
    bus.wen   = w;
    bus.din   = d;
    bus.ren   = r;
    bus.clear = c;
    if (exp_rd) sb.push_back(exp_val);
    @(posedge clk);
    #1;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] e);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, e);
  endtask

  // Monitor: any accepted read must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && bus.ren && bus.valid && !bus.clear) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h expected no read at %0t", bus.dout, $time);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (bus.dout !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h at %0t", bus.dout, e, $time);
        end
      end
    end
  end

  initial begin
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0; bus.din = '0;
    #2;
    chk_flags("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reset.dout", bus.dout, 32'h0);
`ifdef FIFO_GATHER_ERR_FLAG_EN
    chk("reset.err", 32'(bus.err), 32'h0);
`endif
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Threshold: three words not enough, fourth raises valid.
    wr(8'd1); wr(8'd2); wr(8'd3);
    chk_flags("three", 1'b0, 1'b0, 1'b1, 1'b0);
    wr(8'd4);
    chk_flags("four", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("four.dout", bus.dout, 32'h04030201);
    rd(32'h04030201);
    chk_flags("drain1", 1'b1, 1'b0, 1'b1, 1'b0);

    // Fill to full, overflow write ignored, drain two groups.
    for (int i = 1; i <= 8; i++) wr(8'(i));
    chk_flags("full8", 1'b0, 1'b1, 1'b0, 1'b1);
    wr(8'd9);
    chk_flags("ovf", 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_GATHER_ERR_FLAG_EN
    chk("ovf.err", 32'(bus.err), 32'h1);
`endif
    rd(32'h04030201);
    chk_flags("half", 1'b0, 1'b0, 1'b1, 1'b1);
    rd(32'h08070605);
    chk_flags("drain2", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0);
`ifdef FIFO_GATHER_ERR_FLAG_EN
    chk("clr1.err", 32'(bus.err), 32'h0);
`endif

    // Simultaneous write and read accept.
    wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4);
    step(1'b1, 8'd5, 1'b1, 1'b0, 1'b1, 32'h04030201);
    chk_flags("simul", 1'b0, 1'b0, 1'b1, 1'b0);
    wr(8'd6); wr(8'd7); wr(8'd8);
    chk("simul.dout", bus.dout, 32'h08070605);
    rd(32'h08070605);
    chk_flags("simul_drain", 1'b1, 1'b0, 1'b1, 1'b0);

    // Write pointer wraps: rptr at 4, eight words span addresses 4..7,0..3.
    wr(8'h20); wr(8'h21); wr(8'h22); wr(8'h23);
    rd(32'h23222120);
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
    chk_flags("wrap_full", 1'b0, 1'b1, 1'b0, 1'b1);
    rd(32'h13121110);
    rd(32'h17161514);
    chk_flags("wrap_drain", 1'b1, 1'b0, 1'b1, 1'b0);

    // Clear beats same-cycle write and read; the write must not land.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk_flags("pre_clr", 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 32'h0);
    chk_flags("post_clr", 1'b1, 1'b0, 1'b1, 1'b0);
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    rd(32'hA4A3A2A1);

    // Read on empty is ignored.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_flags("rd_empty", 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FIFO_GATHER_ERR_FLAG_EN
    chk("rd_empty.err", 32'(bus.err), 32'h1);
    wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34);
    rd(32'h34333231);
    chk("sticky.err", 32'(bus.err), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("clr2.err", 32'(bus.err), 32'h0);
`endif

    // Async reset mid-fill takes effect between edges.
    wr(8'h55); wr(8'h66); wr(8'h77); wr(8'h88);
    chk_flags("pre_rst", 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk_flags("async_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("async_rst.dout", bus.dout, 32'h0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4);
    rd(32'hC4C3C2C1);
    chk_flags("after_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
